// File: rtl/hsid_fifo_pkg.sv
// Shared constants and types for the hsid FIFO slice.
package hsid_fifo_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH      = 16;
   localparam int unsigned DEFAULT_FIFO_ADDR_WIDTH = 4;

   // Occupancy status, all derived from the registered count.
   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
   } fifo_flags_t;

endpackage

// File: rtl/hsid_fifo_ram.sv
// FIFO storage: one write port, one registered read port sharing the read address.
// i_wr_copy makes the write port store the word at i_raddr instead of i_wdata (recirculation).
module hsid_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic                  i_wr_copy,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] w_wr_word;

   assign w_wr_word = i_wr_copy ? r_mem[i_raddr] : i_wdata;

   // Array write, no reset on storage.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= w_wr_word;
      end
   end

   // Registered read; holds its value when no read is issued.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/hsid_fifo_ext.sv
// Synchronous FIFO with flush, recirculate (loop) mode and threshold flags.
// Optional sticky overflow/underflow flags are built when HSID_FIFO_ERR_FLAGS_EN is defined;
// otherwise both outputs are tied low.
module hsid_fifo_ext
   import hsid_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int unsigned FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_clear,
   input  logic                     i_loop_en,
   input  logic                     i_wr_en,
   input  logic                     i_rd_en,
   input  logic [DATA_WIDTH-1:0]    i_data_in,
   input  logic [FIFO_ADDR_WIDTH:0] i_almost_full_threshold,
   input  logic [FIFO_ADDR_WIDTH:0] i_almost_empty_threshold,
   output logic [DATA_WIDTH-1:0]    o_data_out,
   output logic                     o_data_valid,
   output logic [FIFO_ADDR_WIDTH:0] o_count,
   output logic                     o_full,
   output logic                     o_almost_full,
   output logic                     o_empty,
   output logic                     o_almost_empty,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int unsigned FIFO_DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam logic [FIFO_ADDR_WIDTH:0]   LP_FULL_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [FIFO_ADDR_WIDTH:0]   LP_CNT_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
   localparam logic [FIFO_ADDR_WIDTH-1:0] LP_PTR_ONE  = (FIFO_ADDR_WIDTH)'(1);

   logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
   logic [FIFO_ADDR_WIDTH:0]   r_count;
   logic                       r_data_valid;
   fifo_flags_t                w_flags;
   logic                       w_rd_acc;
   logic                       w_wr_acc;
   logic                       w_loop;

   assign w_flags.full         = (r_count == LP_FULL_CNT);
   assign w_flags.empty        = (r_count == '0);
   assign w_flags.almost_full  = (r_count >= i_almost_full_threshold);
   assign w_flags.almost_empty = (r_count <= i_almost_empty_threshold);

   // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
   assign w_rd_acc = i_rd_en && !w_flags.empty && !i_loop_en && !i_clear;
   assign w_wr_acc = i_wr_en && (!w_flags.full || w_rd_acc) && !i_loop_en && !i_clear;
   assign w_loop   = i_loop_en && !w_flags.empty && !i_clear;

   hsid_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_we      (w_wr_acc || w_loop),
      .i_wr_copy (w_loop),
      .i_waddr   (r_wr_ptr),
      .i_wdata   (i_data_in),
      .i_re      (w_rd_acc || w_loop),
      .i_raddr   (r_rd_ptr),
      .o_rdata   (o_data_out)
   );

   // Pointers, occupancy and read-valid; clear beats loop beats normal traffic.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
      end else if (i_clear) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
      end else if (w_loop) begin
         r_wr_ptr     <= r_wr_ptr + LP_PTR_ONE;
         r_rd_ptr     <= r_rd_ptr + LP_PTR_ONE;
         r_data_valid <= 1'b1;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + LP_CNT_ONE;
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - LP_CNT_ONE;
         end
         r_data_valid <= w_rd_acc;
      end
   end

`ifdef HSID_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags, cleared only by flush or reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_clear) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!i_loop_en) begin
         if (i_wr_en && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end
         if (i_rd_en && w_flags.empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
`else
   assign o_overflow  = 1'b0;
   assign o_underflow = 1'b0;
`endif

   assign o_data_valid   = r_data_valid;
   assign o_count        = r_count;
   assign o_full         = w_flags.full;
   assign o_almost_full  = w_flags.almost_full;
   assign o_empty        = w_flags.empty;
   assign o_almost_empty = w_flags.almost_empty;

endmodule

// File: tb/tb_hsid_fifo_ext.sv
// Scoreboard bench for hsid_fifo_ext: a queue model predicts contents, reads and flags.
module tb_hsid_fifo_ext;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst_n;
   logic        clear, loop_en, wr_en, rd_en;
   logic [15:0] data_in;
   logic [4:0]  af_thr, ae_thr;
   logic [15:0] data_out;
   logic        data_valid;
   logic [4:0]  count;
   logic        full, almost_full, empty, almost_empty, overflow, underflow;

   hsid_fifo_ext #(
      .DATA_WIDTH      (16),
      .FIFO_ADDR_WIDTH (4)
   ) dut (
      .i_clk                    (clk),
      .i_rst_n                  (rst_n),
      .i_clear                  (clear),
      .i_loop_en                (loop_en),
      .i_wr_en                  (wr_en),
      .i_rd_en                  (rd_en),
      .i_data_in                (data_in),
      .i_almost_full_threshold  (af_thr),
      .i_almost_empty_threshold (ae_thr),
      .o_data_out               (data_out),
      .o_data_valid             (data_valid),
      .o_count                  (count),
      .o_full                   (full),
      .o_almost_full            (almost_full),
      .o_empty                  (empty),
      .o_almost_empty           (almost_empty),
      .o_overflow               (overflow),
      .o_underflow              (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          total = 0;
   int          bad   = 0;
   logic [15:0] mq[$];        // model FIFO contents, oldest first
   logic [15:0] sb[$];        // expected read data, in order
   logic [15:0] last_out = '0;
   logic        exp_ovf = 1'b0;
   logic        exp_unf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, then advance the model past the edge.
   task automatic step(input logic wr, input logic rd, input logic lp, input logic clr,
                       input logic [15:0] din);
      int  n;
      bit  racc, wacc;
      logic [15:0] v;
      wr_en = wr; rd_en = rd; loop_en = lp; clear = clr; data_in = din;
      @(posedge clk);
      #1;
      n = mq.size();
      if (clr) begin
         mq.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else if (lp) begin
         if (n > 0) begin
            v = mq.pop_front();
            mq.push_back(v);
            sb.push_back(v);
         end
      end else begin
         racc = rd && (n > 0);
         wacc = wr && ((n < DEPTH) || racc);
`ifdef HSID_FIFO_ERR_FLAGS_EN
         if (wr && !wacc) exp_ovf = 1'b1;
         if (rd && n == 0) exp_unf = 1'b1;
`endif
         if (racc) sb.push_back(mq.pop_front());
         if (wacc) mq.push_back(din);
      end
   endtask

   // Monitor: status against the model every cycle, read data against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("count", 32'(count), 32'(mq.size()));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("almost_full", 32'(almost_full), 32'(mq.size() >= int'(af_thr)));
         chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= int'(ae_thr)));
         chk("overflow", 32'(overflow), 32'(exp_ovf));
         chk("underflow", 32'(underflow), 32'(exp_unf));
         if (data_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 32'(data_valid), 32'd0);
            end else begin
               last_out = sb.pop_front();
               chk("read_data", 32'(data_out), 32'(last_out));
            end
         end else begin
            chk("missing_valid", 32'(sb.size()), 32'd0);
            chk("data_hold", 32'(data_out), 32'(last_out));
         end
      end
   end

   initial begin
      rst_n = 1'b0; clear = 0; loop_en = 0; wr_en = 0; rd_en = 0; data_in = '0;
      af_thr = 5'd12; ae_thr = 5'd2;
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 16'(i));
      chk("filled_full", 32'(full), 32'd1);
      step(1, 0, 0, 0, 16'h0BAD);
      // Paired write/read at full: oldest word out, 0x00AA queued last.
      step(1, 1, 0, 0, 16'h00AA);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 16'h0);
      step(0, 0, 0, 1, 16'h0);

      // Loop mode recirculates A,B,C, then normal reads see them again.
      step(1, 0, 0, 0, 16'h000A);
      step(1, 0, 0, 0, 16'h000B);
      step(1, 0, 0, 0, 16'h000C);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 16'hFFFF);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0);

      // Loop and read on an empty FIFO, then flush.
      step(0, 0, 1, 0, 16'h0);
      step(0, 1, 0, 0, 16'h0);
      step(0, 0, 0, 1, 16'h0);

      // Flush with a concurrent write drops the write.
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16'h0100 + 16'(i));
      step(1, 0, 0, 1, 16'h0EEE);
      chk("clear_empty", 32'(empty), 32'd1);

      // Reset in the middle of a read.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'h0200 + 16'(i));
      wr_en = 0; rd_en = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_data", 32'(data_out), 32'd0);
      chk("midrst_valid", 32'(data_valid), 32'd0);
      mq.delete(); sb.delete(); last_out = '0; exp_ovf = 0; exp_unf = 0;
      rd_en = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step(1, 0, 0, 0, 16'h0300);
      for (int i = 1; i <= 20; i++) step(1, 1, 0, 0, 16'h0300 + 16'(i));
      step(0, 1, 0, 0, 16'h0);

      // Randomized traffic with phases biased towards filling and draining.
      for (int i = 0; i < 3000; i++) begin
         int pw;
         pw = ((i / 300) % 2 == 0) ? 75 : 30;
         if ($urandom_range(0, 99) < 3) begin
            af_thr = 5'($urandom_range(0, 17));
            ae_thr = 5'($urandom_range(0, 17));
         end
         step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
              $urandom_range(0, 99) < 10, $urandom_range(0, 199) < 2, 16'($urandom));
      end
      step(0, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 16'h0);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hsid_fifo_ext.md
HSID_FIFO_EXT -- requirements
Module: hsid_fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter FIFO_ADDR_WIDTH, default 4; FIFO_DEPTH = 2**FIFO_ADDR_WIDTH (localparam).
REQ-003 SHALL have ports: clk in 1, clock (single clock domain, rising edge); rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have: clear in 1, sync flush; loop_en in 1, recirculate mode; wr_en in 1; rd_en in 1; data_in in DATA_WIDTH.
REQ-005 SHALL have: almost_full_threshold in FIFO_ADDR_WIDTH+1; almost_empty_threshold in FIFO_ADDR_WIDTH+1.
REQ-006 SHALL have: data_out out DATA_WIDTH; data_valid out 1; count out FIFO_ADDR_WIDTH+1.
REQ-007 SHALL have: full, almost_full, empty, almost_empty out 1 each; overflow, underflow out 1 each, sticky.

Function
REQ-008 Priority per cycle SHALL be: clear > loop > normal read/write.
REQ-009 rd_acc = rd_en && !empty && !loop_en && !clear; wr_acc = wr_en && (!full || rd_acc) && !loop_en && !clear.
REQ-010 wr_acc SHALL store data_in at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
REQ-011 rd_acc SHALL load mem[rd_ptr] into data_out next cycle with data_valid=1 for exactly that cycle; rd_ptr wraps.
REQ-012 count SHALL be +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; range 0..DEPTH.
REQ-013 Simultaneous write and read when full SHALL both be accepted; count stays DEPTH.
REQ-014 Loop (loop_en && !empty && !clear): data_out <= mem[rd_ptr], mem[wr_ptr] <= mem[rd_ptr], both ptrs advance, count unchanged, data_valid=1 next cycle; wr_en/rd_en ignored.
REQ-015 loop_en with empty FIFO SHALL be a no-op: data_valid=0, no flags set.
REQ-016 clear SHALL zero wr_ptr, rd_ptr, count, data_valid, overflow, underflow next cycle; memory and data_out retained.
REQ-017 full = (count==DEPTH); empty = (count==0); both combinational from registered count.
REQ-018 almost_full = (count >= almost_full_threshold); almost_empty = (count <= almost_empty_threshold); thresholds unsigned, full (ADDR+1)-bit compare.
REQ-019 data_out SHALL hold its last value when data_valid=0.

Reset
REQ-020 rst_n low SHALL asynchronously set: ptrs 0, count 0, data_out 0, data_valid 0, overflow 0, underflow 0; memory not reset.
REQ-021 Reset asserted mid-operation SHALL discard in-flight read; first cycle after release is idle (empty=1, almost_empty=1).

Configuration
REQ-022 Macro HSID_FIFO_ERR_FLAGS_EN defined: overflow sets on wr_en && !wr_acc && !loop_en && !clear; underflow sets on rd_en && empty && !loop_en && !clear; both hold until clear or reset.
REQ-023 Macro undefined: overflow and underflow SHALL be tied 0, no flag logic synthesised; all other behaviour identical.

Structure
REQ-024 Package hsid_fifo_pkg SHALL hold default DATA_WIDTH/FIFO_ADDR_WIDTH constants and the flag struct type (full, almost_full, empty, almost_empty).
REQ-025 Storage SHALL be sub-module hsid_fifo_ram: one write port, one registered read port, no reset on array.
REQ-026 Pointer/count/flag control SHALL stay in hsid_fifo_ext top.

Verification (DATA_WIDTH=16, FIFO_ADDR_WIDTH=4, thresholds AF=12, AE=2)
REQ-027 Write 16 words 0x0001..0x0010 -> full=1, count=16, almost_full from count 12; 17th wr_en -> rejected, overflow=1 (macro on).
REQ-028 Full FIFO, wr_en+rd_en same cycle with 0x00AA -> data_out=0x0001 next cycle, count stays 16, 0x00AA read last.
REQ-029 Fill 3 words A,B,C, loop_en 3 cycles -> data_out A,B,C with data_valid=1, count=3; then rd x3 -> A,B,C again.
REQ-030 rd_en on empty -> data_valid=0, underflow=1 (macro on) / 0 (macro off); clear next cycle -> underflow=0.
REQ-031 8 words stored, clear with wr_en=1 -> next cycle count=0, empty=1, ptrs 0, write dropped.
REQ-032 rst_n low mid-read at count=5 -> immediately count=0, data_out=0, data_valid=0; after release, 20 write/read wrap cycles return data in order.
